// File: rtl/conv2_maxpool.sv
// 2x2 stride-2 signed max pooling over a MAP_W x MAP_W raster-order stream.
// Build option CONV2_POOL_RELU_EN clamps negative pooled results to zero.
module conv2_maxpool #(
   parameter int unsigned MAP_W     = 8,
   parameter int unsigned DATA_BITS = 14
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        valid_in,
   input  logic signed [DATA_BITS-1:0] data_in,
   output logic signed [DATA_BITS-1:0] data_out,
   output logic                        valid_out,
   output logic                        frame_done
);

   localparam int unsigned CW   = $clog2(MAP_W);
   localparam int unsigned IW   = CW - 1;
   localparam int unsigned HALF = MAP_W / 2;
   localparam logic [CW-1:0] LAST = CW'(MAP_W - 1);

   logic [CW-1:0]               col;
   logic [CW-1:0]               row;
   logic signed [DATA_BITS-1:0] held;
   logic signed [DATA_BITS-1:0] line_buf [HALF];

   logic [IW-1:0]               idx_c;
   logic signed [DATA_BITS-1:0] pair_max_c;
   logic signed [DATA_BITS-1:0] above_c;
   logic signed [DATA_BITS-1:0] pooled_c;
   logic signed [DATA_BITS-1:0] result_c;
   logic                        col_last_c;
   logic                        row_last_c;

   // Horizontal pair max, vertical combine with the buffered upper row.
   always_comb begin
      idx_c      = col[CW-1:1];
      col_last_c = (col == LAST);
      row_last_c = (row == LAST);
      pair_max_c = (held > data_in) ? held : data_in;
      above_c    = line_buf[idx_c];
      pooled_c   = (above_c > pair_max_c) ? above_c : pair_max_c;
`ifdef CONV2_POOL_RELU_EN
      result_c   = pooled_c[DATA_BITS-1] ? '0 : pooled_c;
`else
      result_c   = pooled_c;
`endif
   end

   // Raster position and left-hand sample of the current pair.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col  <= '0;
         row  <= '0;
         held <= '0;
      end else if (valid_in) begin
         if (col_last_c) begin
            col <= '0;
            row <= row_last_c ? '0 : row + CW'(1);
         end else begin
            col <= col + CW'(1);
         end
         if (!col[0]) begin
            held <= data_in;
         end
      end
   end

   // Upper-row pair maxima; contents are always rewritten before use.
   always_ff @(posedge clk) begin
      if (valid_in && col[0] && !row[0]) begin
         line_buf[idx_c] <= pair_max_c;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_out   <= '0;
         valid_out  <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         valid_out  <= 1'b0;
         frame_done <= 1'b0;
         if (valid_in && col[0] && row[0]) begin
            data_out   <= result_c;
            valid_out  <= 1'b1;
            frame_done <= col_last_c && row_last_c;
         end
      end
   end

endmodule

// File: tb/tb_conv2_maxpool.sv
// Scoreboard bench for conv2_maxpool (MAP_W=8, DATA_BITS=14).
module tb_conv2_maxpool;

   localparam int MW = 8;
   localparam int DB = 14;

   logic                 clk = 1'b0;
   logic                 rst = 1'b0;
   logic                 valid_in = 1'b0;
   logic signed [DB-1:0] data_in = '0;
   logic signed [DB-1:0] data_out;
   logic                 valid_out;
   logic                 frame_done;

   int checks = 0;
   int passes = 0;
   int cyc = 0;
   int out_count = 0;
   int fd_count = 0;
   logic signed [DB-1:0] first_out;

   logic signed [DB-1:0] stream [128];
   logic signed [DB-1:0] q_val [$];
   logic                 q_fd  [$];
   int                   q_cyc [$];

   conv2_maxpool #(.MAP_W(MW), .DATA_BITS(DB)) dut (
      .clk(clk), .rst(rst), .valid_in(valid_in), .data_in(data_in),
      .data_out(data_out), .valid_out(valid_out), .frame_done(frame_done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic signed [DB-1:0] smax(input logic signed [DB-1:0] a,
                                                 input logic signed [DB-1:0] b);
      return (a > b) ? a : b;
   endfunction

   // Scoreboard: every valid_out must match the oldest pending window result.
   always @(negedge clk) begin
      logic signed [DB-1:0] ev;
      logic ef;
      int ec;
      if (valid_out === 1'b1) begin
         if (out_count == 0) first_out = data_out;
         out_count++;
         if (frame_done === 1'b1) fd_count++;
         checks++;
         if (q_val.size() == 0) begin
            $display("FAIL unexpected_valid_out: got data=%0d fd=%0b, required no output", data_out, frame_done);
         end else begin
            ev = q_val.pop_front();
            ef = q_fd.pop_front();
            ec = q_cyc.pop_front();
            if (data_out !== ev || frame_done !== ef || cyc !== ec)
               $display("FAIL pooled_output: got data=%0d fd=%0b cyc=%0d, required data=%0d fd=%0b cyc=%0d",
                        data_out, frame_done, cyc, ev, ef, ec);
            else passes++;
         end
      end else if (frame_done !== 1'b0) begin
         checks++;
         $display("FAIL stray_frame_done: got %0b without valid_out, required 0", frame_done);
      end
   end

   // Drive stream[0..n-1]; gap_mode inserts idle cycles with junk data.
   task automatic drive(input int n, input int gap_mode);
      for (int i = 0; i < n; i++) begin
         int g, p, r, c, b;
         logic signed [DB-1:0] e;
         g = 0;
         if (gap_mode != 0) g = 1 + ((i % 4 == 0) ? int'($urandom_range(0, 5)) : 0);
         repeat (g) begin
            @(negedge clk);
            valid_in = 1'b0;
            data_in  = DB'($urandom);
         end
         @(negedge clk);
         valid_in = 1'b1;
         data_in  = stream[i];
         p = i % (MW * MW);
         b = i - p;
         r = p / MW;
         c = p % MW;
         if ((r % 2 == 1) && (c % 2 == 1)) begin
            e = smax(smax(stream[b + (r-1)*MW + c-1], stream[b + (r-1)*MW + c]),
                     smax(stream[b + r*MW + c-1],     stream[b + r*MW + c]));
`ifdef CONV2_POOL_RELU_EN
            if (e < 0) e = '0;
`endif
            q_val.push_back(e);
            q_fd.push_back(p == MW*MW - 1);
            q_cyc.push_back(cyc + 1);
         end
      end
      @(negedge clk);
      valid_in = 1'b0;
   endtask

   task automatic fill_ramp(input int base);
      for (int i = 0; i < 64; i++) stream[base + i] = DB'(i);
   endtask

   task automatic start_run();
      out_count = 0;
      fd_count  = 0;
   endtask

   task automatic end_run(input string name, input int n_out, input int n_fd);
      repeat (3) @(negedge clk);
      checks++;
      if (q_val.size() !== 0 || out_count !== n_out || fd_count !== n_fd)
         $display("FAIL %s_counts: got outputs=%0d frame_done=%0d pending=%0d, required %0d/%0d/0",
                  name, out_count, fd_count, q_val.size(), n_out, n_fd);
      else passes++;
   endtask

   task automatic test_reset();
      #1 rst = 1'b1;
      #1;
      checks++;
      if (data_out !== '0 || valid_out !== 1'b0 || frame_done !== 1'b0)
         $display("FAIL reset_async: got data=%0d v=%0b fd=%0b, required 0/0/0", data_out, valid_out, frame_done);
      else passes++;
      repeat (3) @(negedge clk);
      checks++;
      if (data_out !== '0 || valid_out !== 1'b0 || frame_done !== 1'b0)
         $display("FAIL reset_hold: got data=%0d v=%0b fd=%0b, required 0/0/0", data_out, valid_out, frame_done);
      else passes++;
      rst = 1'b0;
   endtask

   task automatic test_ramp();
      start_run();
      fill_ramp(0);
      drive(64, 0);
      end_run("ramp", 16, 1);
      checks++;
      if (data_out !== DB'(63)) $display("FAIL ramp_hold: got %0d, required 63", data_out);
      else passes++;
   endtask

   task automatic test_all_negative();
      logic signed [DB-1:0] want;
      start_run();
      for (int i = 0; i < 64; i++) stream[i] = -DB'(5);
      drive(64, 0);
      end_run("all_neg", 16, 1);
`ifdef CONV2_POOL_RELU_EN
      want = '0;
`else
      want = -DB'(5);
`endif
      checks++;
      if (first_out !== want) $display("FAIL all_neg_first: got %0d, required %0d", first_out, want);
      else passes++;
   endtask

   task automatic test_corners();
      for (int k = 0; k < 4; k++) begin
         start_run();
         for (int i = 0; i < 64; i++) stream[i] = -DB'(8192);
         stream[(k / 2) * MW + (k % 2)] = DB'(100);
         drive(64, 0);
         end_run("corner", 16, 1);
         checks++;
         if (first_out !== DB'(100)) $display("FAIL corner_%0d_first: got %0d, required 100", k, first_out);
         else passes++;
      end
   endtask

   task automatic test_gaps();
      start_run();
      fill_ramp(0);
      drive(64, 1);
      end_run("gaps", 16, 1);
      checks++;
      if (first_out !== DB'(9)) $display("FAIL gaps_first: got %0d, required 9", first_out);
      else passes++;
   endtask

   task automatic test_mid_reset();
      start_run();
      fill_ramp(0);
      drive(37, 0);
      @(negedge clk);
      checks++;
      if (data_out !== DB'(31)) $display("FAIL pre_reset_data: got %0d, required 31", data_out);
      else passes++;
      #2 rst = 1'b1;
      #1;
      checks++;
      if (data_out !== '0) $display("FAIL mid_reset_async: got %0d, required 0", data_out);
      else passes++;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         valid_in = 1'b1;
         data_in  = DB'($urandom);
         checks++;
         if (valid_out !== 1'b0) $display("FAIL valid_in_reset: got %0b, required 0", valid_out);
         else passes++;
      end
      @(negedge clk);
      valid_in = 1'b0;
      rst = 1'b0;
      start_run();
      drive(64, 0);
      end_run("after_reset", 16, 1);
      checks++;
      if (first_out !== DB'(9) || data_out !== DB'(63))
         $display("FAIL after_reset_values: got first=%0d last=%0d, required 9/63", first_out, data_out);
      else passes++;
   endtask

   task automatic test_back_to_back();
      start_run();
      fill_ramp(0);
      for (int i = 64; i < 128; i++) stream[i] = DB'($urandom);
      stream[64] = DB'(8191);
      stream[73] = -DB'(8192);
      stream[126] = -DB'(8192);
      stream[127] = -DB'(8191);
      drive(128, 0);
      end_run("back_to_back", 32, 2);
   endtask

   initial begin
      test_reset();
      test_ramp();
      test_all_negative();
      test_corners();
      test_gaps();
      test_mid_reset();
      test_back_to_back();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/conv2_maxpool.md
CONV2_MAXPOOL -- requirements
Module: conv2_maxpool

Interface
REQ-001 SHALL have parameter MAP_W, default 8: input feature-map width and height in samples; even, 4..64.
REQ-002 SHALL have parameter DATA_BITS, default 14: signed sample width.
REQ-003 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1: reset, asynchronous, active-high.
REQ-005 SHALL have port valid_in  input  1: one-cycle qualifier; data_in is accepted on each rising edge where valid_in=1.
REQ-006 SHALL have port data_in  input  DATA_BITS signed: convolution sum sample, raster order (row-major).
REQ-007 SHALL have port data_out  output  DATA_BITS signed: pooled sample, registered.
REQ-008 SHALL have port valid_out  output  1: one-cycle pulse qualifying data_out.
REQ-009 SHALL have port frame_done  output  1: one-cycle pulse coincident with the last pooled output of a map.

Function
REQ-010 SHALL perform 2x2 max pooling, stride 2, on a MAP_W x MAP_W map, giving (MAP_W/2)^2 outputs per map in raster order.
REQ-011 SHALL keep column counter col (0..MAP_W-1) and row counter row (0..MAP_W-1); both advance only on accepted samples; col wraps to 0 and increments row after MAP_W-1; row wraps to 0 after MAP_W-1.
REQ-012 SHALL register the sample at even col; at odd col SHALL form pair_max = signed max(held, data_in).
REQ-013 On even row, pair_max SHALL be written to line buffer entry col/2 (MAP_W/2 entries x DATA_BITS).
REQ-014 On odd row, the output SHALL be signed max(buffer[col/2], pair_max), registered to data_out with valid_out=1 on the next rising edge (latency 1 cycle after the accepting edge of the bottom-right sample).
REQ-015 Signed comparison SHALL be used throughout; ties SHALL select either operand (equal value).
REQ-016 frame_done SHALL pulse with the valid_out for the sample at row=MAP_W-1, col=MAP_W-1; counters are then at 0 and the next accepted sample starts a new map with no idle cycle required.
REQ-017 Gaps of any length between valid_in pulses SHALL NOT change results; back-to-back valid_in every cycle SHALL be supported.
REQ-018 valid_out and frame_done SHALL be 0 on all cycles not specified above; data_out SHALL hold its last value when valid_out=0.
REQ-019 There is no backpressure; the consumer SHALL accept every valid_out pulse.

Reset
REQ-020 rst=1 SHALL asynchronously clear col, row, held sample, data_out, valid_out, frame_done to 0; line buffer contents need not be cleared.
REQ-021 Reset mid-map SHALL discard the partial map; the first sample accepted after rst deasserts is row 0, col 0.

Configuration
REQ-022 Macro CONV2_POOL_RELU_EN: when defined, data_out SHALL be max(pooled,0) (negative results become 0); when undefined, data_out SHALL be the signed pooled value unmodified; timing identical in both builds.

Verification
REQ-023 MAP_W=8, data_in = row*8+col (0..63) every cycle -> 16 valid_out pulses: 9,11,13,15,25,...,63; frame_done only with 63.
REQ-024 Single window all -5 (e.g. MAP_W=4, data_in=-5 for all 16) -> with macro defined 4 outputs of 0; undefined 4 outputs of -5.
REQ-025 Max at each corner of window 0 in turn (value 100, others -8192) -> first output 100 in each of four runs.
REQ-026 Same stream as REQ-023 with valid_in on alternate cycles plus random 0-5 cycle gaps -> identical output sequence, each valid_out one cycle after the 2nd-row odd-col sample.
REQ-027 rst pulsed after 37 samples, then a fresh 64-sample map -> no valid_out during reset, output sequence exactly as REQ-023.
REQ-028 Two maps back-to-back with no gap -> 32 outputs, frame_done pulses exactly twice.
